// File: rtl/ppu_nmi_generator.sv
// ppu_nmi_generator
//   Tracks the PPU dot/scanline position and frame parity, maintains the
//   PPUSTATUS vblank flag and drives the registered active-low NMI request
//   that feeds the CPU's falling-edge NMI detector.
//
// Ports
//   clk                system clock, rising edge
//   rst_n              synchronous active-low reset
//   dot_en             one-clk pixel-clock enable; position advances when high
//   nmi_enable         PPUCTRL bit 7 (level)
//   rendering_enabled  PPUMASK bg/sprite enable (level); used only for odd-frame skip
//   status_read        one-clk pulse, CPU read of $2002
//   nmi_n              registered NMI request, active low
//   vblank_flag        PPUSTATUS bit 7
//   scanline, dot      current position (9-bit)
//   frame_odd          toggles at every frame wrap
//
// Build option
//   PPU_ODD_FRAME_SKIP_EN  when defined, odd frames with rendering enabled
//                          skip the final dot of the pre-render line.
//
// Position    | meaning
//   (VBL,0->1)  | vblank flag set (unless a status read races it)
//   (PRE,0->1)  | vblank flag cleared
//   (LAST,LAST) | frame wrap to (0,0), frame_odd toggles

module ppu_nmi_generator #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dot_en,
  input  logic       nmi_enable,
  input  logic       rendering_enabled,
  input  logic       status_read,
  output logic       nmi_n,
  output logic       vblank_flag,
  output logic [8:0] scanline,
  output logic [8:0] dot,
  output logic       frame_odd
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
  localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

  logic [8:0] dot_nxt;
  logic [8:0] line_nxt;
  logic       odd_nxt;
  logic       flag_nxt;
  logic       skip_dot;
  logic       set_evt;
  logic       clr_evt;

`ifdef PPU_ODD_FRAME_SKIP_EN
  // Odd frame with rendering on: the pre-render line ends one dot early.
  assign skip_dot = frame_odd & rendering_enabled &
                    (scanline == PRE_LINE) & (dot == DOT_LAST - 9'd1);
`else
  logic unused_rendering;
  assign unused_rendering = rendering_enabled;
  assign skip_dot = 1'b0;
`endif

  // Both events fire on the edge that leaves dot 0 of their line.
  assign set_evt = dot_en & (scanline == VBL_LINE) & (dot == 9'd0);
  assign clr_evt = status_read | (dot_en & (scanline == PRE_LINE) & (dot == 9'd0));

  always_comb begin
    dot_nxt  = dot;
    line_nxt = scanline;
    odd_nxt  = frame_odd;
    if (dot_en) begin
      if (skip_dot) begin
        dot_nxt  = 9'd0;
        line_nxt = 9'd0;
        odd_nxt  = ~frame_odd;
      end else if (dot == DOT_LAST) begin
        dot_nxt = 9'd0;
        if (scanline == LINE_LAST) begin
          line_nxt = 9'd0;
          odd_nxt  = ~frame_odd;
        end else begin
          line_nxt = scanline + 9'd1;
        end
      end else begin
        dot_nxt = dot + 9'd1;
      end
    end
  end

  // Clear beats set, so a status read on the set edge suppresses the
  // whole vblank for this frame.
  always_comb begin
    flag_nxt = vblank_flag;
    if (clr_evt)      flag_nxt = 1'b0;
    else if (set_evt) flag_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dot         <= 9'd0;
      scanline    <= 9'd0;
      frame_odd   <= 1'b0;
      vblank_flag <= 1'b0;
      nmi_n       <= 1'b1;
    end else begin
      dot         <= dot_nxt;
      scanline    <= line_nxt;
      frame_odd   <= odd_nxt;
      vblank_flag <= flag_nxt;
      // Built from the next flag value so nmi_n moves on the same edge.
      nmi_n       <= ~(flag_nxt & nmi_enable);
    end
  end

endmodule

// File: tb/tb_ppu_nmi_generator.sv
// Directed bench for ppu_nmi_generator using a scaled-down raster so whole
// frames fit in a short run; expectations use the same formulas as the
// full-size raster (set after VBL*D+1 edges, clear after PRE*D+1 edges).

module tb_ppu_nmi_generator;

  localparam int D   = 24;
  localparam int L   = 14;
  localparam int VBL = 10;
  localparam int PRE = 13;
  localparam int FRAME = D * L;

`ifdef PPU_ODD_FRAME_SKIP_EN
  localparam int ODD_LEN = FRAME - 1;
`else
  localparam int ODD_LEN = FRAME;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dot_en;
  logic       nmi_enable;
  logic       rendering_enabled;
  logic       status_read;
  logic       nmi_n;
  logic       vblank_flag;
  logic [8:0] scanline;
  logic [8:0] dot;
  logic       frame_odd;

  int checks   = 0;
  int failures = 0;

  ppu_nmi_generator #(
    .DOTS_PER_LINE  (D),
    .LINES_PER_FRAME(L),
    .VBLANK_LINE    (VBL),
    .PRERENDER_LINE (PRE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dot_en           (dot_en),
    .nmi_enable       (nmi_enable),
    .rendering_enabled(rendering_enabled),
    .status_read      (status_read),
    .nmi_n            (nmi_n),
    .vblank_flag      (vblank_flag),
    .scanline         (scanline),
    .dot              (dot),
    .frame_odd        (frame_odd)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int l, input int d, output int saw_flag, output int saw_low);
    int n;
    n = 0;
    saw_flag = 0;
    saw_low  = 0;
    while (!(scanline == 9'(l) && dot == 9'(d)) && n < 2000) begin
      tick();
      n++;
      if (vblank_flag) saw_flag = 1;
      if (!nmi_n)      saw_low  = 1;
    end
    checks++;
    assert (n < 2000) else begin
      failures++;
      $error("FAIL run_to_timeout observed=%0d expected=<2000 target=(%0d,%0d)", n, l, d);
    end
  endtask

  task automatic measure(output int len);
    len = 0;
    do begin
      tick();
      len++;
    end while (!(scanline == 9'd0 && dot == 9'd0) && len < 2000);
  endtask

  initial begin
    int sf, sl, len;
    rst_n = 1'b0; dot_en = 1'b0; nmi_enable = 1'b1;
    rendering_enabled = 1'b0; status_read = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk("rst_dot",   dot, 0);
    chk("rst_line",  scanline, 0);
    chk("rst_flag",  vblank_flag, 0);
    chk("rst_nmi",   nmi_n, 1);
    chk("rst_odd",   frame_odd, 0);

    // no movement without dot_en
    tick(3);
    chk("hold_dot", dot, 0);

    // frame 0: counted edges
    dot_en = 1'b1;
    tick();
    chk("edge1_dot", dot, 1);
    tick(VBL * D - 1);
    chk("pre_set_line", scanline, VBL);
    chk("pre_set_dot",  dot, 0);
    chk("pre_set_flag", vblank_flag, 0);
    chk("pre_set_nmi",  nmi_n, 1);
    tick();
    chk("set_flag", vblank_flag, 1);
    chk("set_nmi",  nmi_n, 0);
    chk("set_dot",  dot, 1);
    tick((PRE - VBL) * D - 1);
    chk("pre_clr_line", scanline, PRE);
    chk("pre_clr_flag", vblank_flag, 1);
    tick();
    chk("clr_flag", vblank_flag, 0);
    chk("clr_nmi",  nmi_n, 1);
    tick(D - 1);
    chk("wrap_line", scanline, 0);
    chk("wrap_dot",  dot, 0);
    chk("wrap_odd",  frame_odd, 1);

    // frame 1: status read mid-vblank
    run_to(VBL, 1, sf, sl);
    chk("f1_flag", vblank_flag, 1);
    chk("f1_nmi",  nmi_n, 0);
    run_to(VBL + 2, 5, sf, sl);
    status_read = 1'b1;
    tick();
    status_read = 1'b0;
    chk("rd_flag", vblank_flag, 0);
    chk("rd_nmi",  nmi_n, 1);
    run_to(0, 0, sf, sl);
    chk("rd_rest_flag", sf, 0);
    chk("rd_rest_low",  sl, 0);
    chk("f1_wrap_odd",  frame_odd, 0);

    // frame 2: read races the set edge
    run_to(VBL, 0, sf, sl);
    status_read = 1'b1;
    tick();
    status_read = 1'b0;
    chk("race_flag", vblank_flag, 0);
    chk("race_nmi",  nmi_n, 1);
    run_to(0, 0, sf, sl);
    chk("race_frame_flag", sf, 0);
    chk("race_frame_low",  sl, 0);
    run_to(VBL, 1, sf, sl);
    chk("after_race_flag", vblank_flag, 1);
    chk("after_race_nmi",  nmi_n, 0);

    // frame 4: enable toggling during vblank
    run_to(0, 0, sf, sl);
    nmi_enable = 1'b0;
    run_to(VBL, 1, sf, sl);
    chk("dis_flag", vblank_flag, 1);
    chk("dis_nmi",  nmi_n, 1);
    run_to(VBL + 1, 10, sf, sl);
    nmi_enable = 1'b1;
    chk("en1_before", nmi_n, 1);
    tick();
    chk("en1_after", nmi_n, 0);
    run_to(VBL + 2, 0, sf, sl);
    nmi_enable = 1'b0;
    tick();
    chk("dis2_nmi", nmi_n, 1);
    chk("dis2_flag", vblank_flag, 1);
    run_to(VBL + 2, 5, sf, sl);
    nmi_enable = 1'b1;
    tick();
    chk("en2_after", nmi_n, 0);

    // reset in the middle of vblank
    run_to(VBL + 2, 15, sf, sl);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_line", scanline, 0);
    chk("mrst_dot",  dot, 0);
    chk("mrst_flag", vblank_flag, 0);
    chk("mrst_nmi",  nmi_n, 1);
    chk("mrst_odd",  frame_odd, 0);

    // frame lengths with rendering enabled
    rendering_enabled = 1'b1;
    measure(len);
    chk("len_f0", len, FRAME);
    chk("len_f0_odd", frame_odd, 1);
    measure(len);
    chk("len_f1", len, ODD_LEN);
    chk("len_f1_odd", frame_odd, 0);
    measure(len);
    chk("len_f2", len, FRAME);

    // rendering off: odd frame is full length
    rendering_enabled = 1'b0;
    measure(len);
    chk("len_f3_norender", len, FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
